// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between the core (port 0) and debug/DMA (port 1).
// Optional macro DMEM_ARB_RR_EN selects round-robin conflict resolution; default is port-0 fixed priority.
module dmem_arbiter #(
    parameter int DEPTH        = 64,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_valid,
    output logic        p0_ready,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    output logic        p0_err,
    input  logic        p1_valid,
    output logic        p1_ready,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic        p1_lock,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        p1_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    localparam int IW = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_e;

    lock_e         lock_q;
    logic [IW-1:0] idle_q;
    logic [IW-1:0] idle_d;
    logic          prefer0;
    logic          gnt0, gnt1;
    logic [31:0]   widx0, widx1;
    logic          ill0, ill1;

    assign widx0 = {2'b00, p0_addr[31:2]};
    assign widx1 = {2'b00, p1_addr[31:2]};
    assign ill0  = (p0_addr[1:0] != 2'b00) || (widx0 >= 32'(DEPTH));
    assign ill1  = (p1_addr[1:0] != 2'b00) || (widx1 >= 32'(DEPTH));

`ifdef DMEM_ARB_RR_EN
    // Remembers who was served last so a conflict goes to the other port.
    logic favor_p1_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            favor_p1_q <= 1'b0;
        end else if (gnt0) begin
            favor_p1_q <= 1'b1;
        end else if (gnt1) begin
            favor_p1_q <= 1'b0;
        end
    end

    assign prefer0 = !favor_p1_q;
`else
    assign prefer0 = 1'b1;
`endif

    // Grants are gated by rst so nothing is accepted while the block is held in reset.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst) begin
            if (lock_q == LOCKED) begin
                gnt1 = p1_valid;
            end else if (p0_valid && p1_valid) begin
                gnt0 = prefer0;
                gnt1 = !prefer0;
            end else begin
                gnt0 = p0_valid;
                gnt1 = p1_valid;
            end
        end
    end

    assign p0_ready = gnt0;
    assign p1_ready = gnt1;

    // Illegal requests still present their address but never strobe the memory.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt0) begin
            mem_addr  = widx0;
            mem_wdata = p0_wdata;
            mem_read  = !ill0 && !p0_we;
            mem_write = !ill0 && p0_we;
        end else if (gnt1) begin
            mem_addr  = widx1;
            mem_wdata = p1_wdata;
            mem_read  = !ill1 && !p1_we;
            mem_write = !ill1 && p1_we;
        end
    end

    // NOTE: sequential state uses non-blocking assignments and async active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p0_rvalid <= 1'b0;
            p0_err    <= 1'b0;
            p0_rdata  <= '0;
        end else begin
            p0_rvalid <= gnt0;
            p0_err    <= gnt0 && ill0;
            if (gnt0) begin
                p0_rdata <= (!ill0 && !p0_we) ? mem_rdata : 32'h0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p1_rvalid <= 1'b0;
            p1_err    <= 1'b0;
            p1_rdata  <= '0;
        end else begin
            p1_rvalid <= gnt1;
            p1_err    <= gnt1 && ill1;
            if (gnt1) begin
                p1_rdata <= (!ill1 && !p1_we) ? mem_rdata : 32'h0;
            end
        end
    end

    assign idle_d = idle_q + 1'b1;

    // An accepted port-1 request takes precedence over the idle timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_q <= UNLOCKED;
            idle_q <= '0;
        end else begin
            case (lock_q)
                UNLOCKED: begin
                    idle_q <= '0;
                    if (gnt1 && p1_lock) begin
                        lock_q <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (gnt1) begin
                        lock_q <= p1_lock ? LOCKED : UNLOCKED;
                        idle_q <= '0;
                    end else if (p1_valid) begin
                        idle_q <= '0;
                    end else if (idle_d == IW'(LOCK_TIMEOUT)) begin
                        lock_q <= UNLOCKED;
                        idle_q <= '0;
                    end else begin
                        idle_q <= idle_d;
                    end
                end
                default: begin
                    lock_q <= UNLOCKED;
                    idle_q <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: expected responses are queued at acceptance and popped one cycle later.
module tb_dmem_arbiter;
    localparam int DEPTH = 64;
`ifdef DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct packed {
        logic        v;
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
    } req_t;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_valid, p0_ready, p0_we, p0_rvalid, p0_err;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic        p1_valid, p1_ready, p1_we, p1_lock, p1_rvalid, p1_err;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] ram     [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    resp_t       q0[$];
    resp_t       q1[$];
    logic [31:0] last0, last1;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_write) ram[mem_addr[5:0]] <= mem_wdata;
    assign mem_rdata = ram[mem_addr[5:0]];

    dmem_arbiter #(.DEPTH(DEPTH), .LOCK_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_lock(p1_lock), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .p1_err(p1_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic req_t wr(input logic [31:0] a, input logic [31:0] d);
        return '{1'b1, 1'b1, a, d};
    endfunction

    function automatic req_t rd(input logic [31:0] a);
        return '{1'b1, 1'b0, a, 32'h0};
    endfunction

    function automatic req_t nop();
        return '{1'b0, 1'b0, 32'h0, 32'h0};
    endfunction

    function automatic logic legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ((a >> 2) < DEPTH);
    endfunction

    // Pops the response expected from the previous cycle's acceptance, or expects silence.
    task automatic drain_responses();
        resp_t r;
        checks++;
        if (q0.size() == 0) begin
            if (p0_rvalid !== 1'b0 || p0_err !== 1'b0 || p0_rdata !== last0) begin
                errors++;
                $display("FAIL p0_quiet: rvalid=%b err=%b rdata=%h, required rvalid=0 err=0 rdata=%h",
                         p0_rvalid, p0_err, p0_rdata, last0);
            end
        end else begin
            r = q0.pop_front();
            last0 = r.data;
            if (p0_rvalid !== 1'b1 || p0_err !== r.err || p0_rdata !== r.data) begin
                errors++;
                $display("FAIL p0_resp: rvalid=%b err=%b rdata=%h, required rvalid=1 err=%b rdata=%h",
                         p0_rvalid, p0_err, p0_rdata, r.err, r.data);
            end
        end
        checks++;
        if (q1.size() == 0) begin
            if (p1_rvalid !== 1'b0 || p1_err !== 1'b0 || p1_rdata !== last1) begin
                errors++;
                $display("FAIL p1_quiet: rvalid=%b err=%b rdata=%h, required rvalid=0 err=0 rdata=%h",
                         p1_rvalid, p1_err, p1_rdata, last1);
            end
        end else begin
            r = q1.pop_front();
            last1 = r.data;
            if (p1_rvalid !== 1'b1 || p1_err !== r.err || p1_rdata !== r.data) begin
                errors++;
                $display("FAIL p1_resp: rvalid=%b err=%b rdata=%h, required rvalid=1 err=%b rdata=%h",
                         p1_rvalid, p1_err, p1_rdata, r.err, r.data);
            end
        end
    endtask

    // One clock of stimulus: drive both ports, check the grant and memory drive, queue the response.
    task automatic cycle(input req_t r0, input req_t r1, input logic lk,
                         input logic eg0, input logic eg1, input string nm);
        req_t        g;
        resp_t       r;
        logic [31:0] ea, ed;
        logic        er, ew, any;
        @(negedge clk);
        drain_responses();
        p0_valid = r0.v; p0_we = r0.we; p0_addr = r0.a; p0_wdata = r0.d;
        p1_valid = r1.v; p1_we = r1.we; p1_addr = r1.a; p1_wdata = r1.d;
        p1_lock  = lk;
        #1;
        checks++;
        if (p0_ready !== eg0 || p1_ready !== eg1) begin
            errors++;
            $display("FAIL %s grant: ready0=%b ready1=%b, required ready0=%b ready1=%b",
                     nm, p0_ready, p1_ready, eg0, eg1);
        end
        any = eg0 || eg1;
        g   = eg0 ? r0 : r1;
        ea  = any ? {2'b00, g.a[31:2]} : 32'h0;
        ed  = any ? g.d : 32'h0;
        er  = any && legal(g.a) && !g.we;
        ew  = any && legal(g.a) && g.we;
        checks++;
        if (mem_read !== er || mem_write !== ew || mem_addr !== ea || mem_wdata !== ed) begin
            errors++;
            $display("FAIL %s mem: rd=%b wr=%b addr=%h wdata=%h, required rd=%b wr=%b addr=%h wdata=%h",
                     nm, mem_read, mem_write, mem_addr, mem_wdata, er, ew, ea, ed);
        end
        if (any) begin
            r.err  = !legal(g.a);
            r.data = er ? ref_mem[g.a[7:2]] : 32'h0;
            if (ew) ref_mem[g.a[7:2]] = g.d;
            if (eg0) q0.push_back(r);
            else     q1.push_back(r);
        end
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) cycle(nop(), nop(), 1'b0, 1'b0, 1'b0, "quiet");
    endtask

    task automatic test_reset();
        rst = 1'b0;
        p0_valid = 1'b1; p0_we = 1'b1; p0_addr = 32'h0; p0_wdata = 32'h1;
        p1_valid = 1'b1; p1_we = 1'b1; p1_addr = 32'h4; p1_wdata = 32'h2; p1_lock = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (p0_ready !== 1'b0 || p1_ready !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0 || p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0 ||
            p0_err !== 1'b0 || p1_err !== 1'b0 || p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: ready=%b%b mem rd/wr=%b%b addr=%h wdata=%h rvalid=%b%b err=%b%b, required all 0",
                     p0_ready, p1_ready, mem_read, mem_write, mem_addr, mem_wdata,
                     p0_rvalid, p1_rvalid, p0_err, p1_err);
        end
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        p1_lock  = 1'b0;
        rst = 1'b1;
        cycle(wr(32'h0, 32'h1), wr(32'h4, 32'h2), 1'b0, 1'b1, 1'b0, "post_reset_first");
        cycle(nop(), wr(32'h4, 32'h2), 1'b0, 1'b0, 1'b1, "post_reset_p1");
        quiet(1);
    endtask

    task automatic test_write_read();
        cycle(wr(32'h10, 32'hDEADBEEF), nop(), 1'b0, 1'b1, 1'b0, "wr_0x10");
        cycle(rd(32'h10), nop(), 1'b0, 1'b1, 1'b0, "rd_0x10");
        cycle(nop(), rd(32'h4), 1'b0, 1'b0, 1'b1, "rd_p1_0x4");
        quiet(2);
    endtask

    task automatic test_illegal();
        cycle(nop(), rd(32'h102), 1'b0, 1'b0, 1'b1, "ill_misaligned");
        cycle(nop(), rd(32'h100), 1'b0, 1'b0, 1'b1, "ill_index64");
        cycle(wr(32'h103, 32'h55), nop(), 1'b0, 1'b1, 1'b0, "ill_p0_write");
        cycle(nop(), wr(32'hFC, 32'h1234), 1'b0, 1'b0, 1'b1, "wr_last_word");
        cycle(nop(), rd(32'hFC), 1'b0, 1'b0, 1'b1, "rd_last_word");
        quiet(2);
    endtask

    task automatic test_arbitration();
        logic eg0;
        cycle(nop(), wr(32'h8, 32'hA5A5), 1'b0, 1'b0, 1'b1, "arb_prime");
        for (int i = 0; i < 4; i++) begin
            eg0 = RR ? (i % 2 == 0) : 1'b1;
            cycle(wr(32'h20 + 4 * i, 32'h100 + i), rd(32'h10), 1'b0, eg0, !eg0, $sformatf("arb%0d", i));
        end
        quiet(2);
    endtask

    task automatic test_lock_timeout();
        cycle(nop(), wr(32'h30, 32'hCAFE), 1'b1, 1'b0, 1'b1, "lock_take");
        for (int i = 1; i <= 16; i++)
            cycle(rd(32'h30), nop(), 1'b0, 1'b0, 1'b0, $sformatf("lock_block%0d", i));
        cycle(rd(32'h30), nop(), 1'b0, 1'b1, 1'b0, "lock_release");
        quiet(1);
        cycle(nop(), rd(32'h10), 1'b1, 1'b0, 1'b1, "relock_take");
        for (int i = 1; i <= 10; i++)
            cycle(rd(32'h0), nop(), 1'b0, 1'b0, 1'b0, $sformatf("relock_a%0d", i));
        cycle(rd(32'h0), wr(32'h34, 32'hBEEF), 1'b1, 1'b0, 1'b1, "relock_hold");
        for (int i = 1; i <= 16; i++)
            cycle(rd(32'h0), nop(), 1'b0, 1'b0, 1'b0, $sformatf("relock_b%0d", i));
        cycle(rd(32'h34), nop(), 1'b0, 1'b1, 1'b0, "relock_release");
        cycle(nop(), rd(32'h30), 1'b1, 1'b0, 1'b1, "unlock_take");
        cycle(rd(32'h0), rd(32'h34), 1'b0, 1'b0, 1'b1, "unlock_drop");
        cycle(rd(32'h0), nop(), 1'b0, 1'b1, 1'b0, "unlock_p0");
        quiet(2);
    endtask

    task automatic test_reset_mid();
        cycle(nop(), rd(32'h10), 1'b1, 1'b0, 1'b1, "rst_read");
        @(posedge clk);
        #1;
        rst = 1'b0;
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        p1_lock  = 1'b0;
        @(negedge clk);
        checks++;
        if (p1_rvalid !== 1'b0 || p1_err !== 1'b0 || p1_rdata !== 32'h0 || p1_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_drop: rvalid=%b err=%b rdata=%h ready=%b, required 0 0 0 0",
                     p1_rvalid, p1_err, p1_rdata, p1_ready);
        end
        q0.delete();
        q1.delete();
        last0 = 32'h0;
        last1 = 32'h0;
        rst = 1'b1;
        cycle(rd(32'h10), rd(32'h14), 1'b0, 1'b1, 1'b0, "rst_mid_unlocked");
        quiet(2);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]     = 32'h0;
            ref_mem[i] = 32'h0;
        end
        last0 = 32'h0;
        last1 = 32'h0;
        test_reset();
        test_write_read();
        test_illegal();
        test_arbitration();
        test_lock_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter and sequencer in front of the single-port data memory. It shares the memory between two requesters: port 0 is the core load/store path and port 1 is the debug/DMA path. Each requester uses a valid/ready request handshake and gets a registered one-cycle response pulse. The block also word-aligns and range-checks addresses, and lets port 1 lock the memory for back-to-back transfers.

## Interface
Parameters:
- DEPTH, 64, memory depth in 32-bit words.
- LOCK_TIMEOUT, 16, idle cycles after which a held port-1 lock is dropped.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- p0_valid / p1_valid  in  1  request present.
- p0_ready / p1_ready  out  1  request accepted this cycle (grant).
- p0_we / p1_we  in  1  1 = write, 0 = read.
- p0_addr / p1_addr  in  32  byte address.
- p0_wdata / p1_wdata  in  32  write data.
- p1_lock  in  1  qualifies a port-1 request: hold ownership after this transfer.
- p0_rvalid / p1_rvalid  out  1  one-cycle response pulse.
- p0_rdata / p1_rdata  out  32  read data, registered.
- p0_err / p1_err  out  1  error response, valid with rvalid.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  32  memory word index.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  combinational memory read data.

## Operation
- **Grant selection** (combinational, from valids and registered state). At most one port is granted per cycle.
  - Only one port valid: that port is granted, unless lock_q is set, in which case only port 1 may be granted.
  - Both valid with lock_q set: port 1 is granted.
  - Both valid with lock_q clear: arbitration per the Configuration section.
  - pX_ready equals the grant.
- **Accepted request**: a request is accepted when pX_valid and pX_ready are both 1.
- **Address check**:
  - Word index is addr[31:2], zero-extended to 32 bits.
  - A request is illegal if addr[1:0] != 0 or the word index >= DEPTH.
  - An illegal request is still accepted, but mem_read and mem_write stay 0.
- **Memory drive**:
  - Legal accepted read: mem_read = 1.
  - Legal accepted write: mem_write = 1.
  - mem_addr and mem_wdata come from the granted port.
  - When nothing is granted, all mem_* outputs are 0.
- **Response**:
  - Every accepted request produces exactly one pX_rvalid pulse on the following cycle.
  - Legal read: pX_rdata = mem_rdata captured at the acceptance edge, err = 0.
  - Legal write: pX_rdata = 0, err = 0.
  - Illegal request: pX_rdata = 0, err = 1.
  - There is no response backpressure.
  - Outside a response pulse, rvalid = 0 and err = 0; rdata holds its last value.
- **Lock FSM** (states UNLOCKED, LOCKED):
  - UNLOCKED -> LOCKED on an accepted port-1 request with p1_lock = 1.
  - LOCKED -> UNLOCKED on an accepted port-1 request with p1_lock = 0.
  - LOCKED -> UNLOCKED when the idle counter reaches LOCK_TIMEOUT.
  - Idle counter: increments each LOCKED cycle with p1_valid = 0, clears on any p1_valid, and is 0 in UNLOCKED.
  - When both a lock clear and a lock set apply in the same cycle, the accepted request wins.

## Timing
- **Reset values**: all rvalid, err, rdata = 0; lock_q = 0; idle counter = 0; round-robin pointer = port 0 favored. mem_read, mem_write, p0_ready and p1_ready are forced 0 while rst is low.
- **Write latency**: the write commits at the acceptance edge. Ack pulse rvalid is high in cycle N+1 for acceptance in cycle N.
- **Read latency**: data is valid in cycle N+1.
- **Throughput**: one transaction per cycle in aggregate. A port may issue back-to-back requests.
- **Reset mid-operation**: a pending response is dropped (no rvalid is produced) and lock is released.
- **Same-cycle read-after-write**: a read accepted the cycle after a write to the same address returns the new data.
- **Timeout boundary**: with LOCK_TIMEOUT = 16, a lock taken and then followed by p1_valid = 0 releases after 16 idle cycles. Port 0 can be granted on the next cycle after release.

## Configuration
- **DMEM_ARB_RR_EN defined**: round-robin arbitration.
  - On a conflict, the port not served by the most recent accepted request is granted.
  - The pointer updates on every accepted request.
- **DMEM_ARB_RR_EN undefined**: fixed priority. Port 0 always wins a conflict when unlocked, and the pointer logic is removed.

## Test plan
- **Reset state**: rst low with both ports valid -> both ready = 0, mem_* = 0, all rvalid = 0. Release reset -> port 0 granted first.
- **Write then read**: port 0 writes 0xDEADBEEF to byte address 0x10, then reads 0x10 -> mem_addr = 4 on both cycles; p0_rvalid pulses twice; second pulse carries p0_rdata = 0xDEADBEEF, err = 0.
- **Illegal addresses**: port 1 reads 0x102 (misaligned), then 0x100 (index 64) -> no mem strobes; p1_rvalid pulses with err = 1, rdata = 0.
- **Round-robin**: with DMEM_ARB_RR_EN defined and both ports valid for 4 cycles -> grants 0,1,0,1. Without the macro -> grants 0,0,0,0.
- **Lock and timeout**: port 1 writes with p1_lock = 1 while port 0 stays valid -> port 0 is blocked. Port 1 then idles 16 cycles -> lock releases and port 0 is granted in cycle 17.
- **Reset during a read**: assert rst in the cycle after a read is accepted -> no rvalid is produced and lock_q = 0.
